data_types_unpacker: RTL and testbench
======================================

// Module: data_types_unpacker
// PURPOSE
//   Receive side of the byte-level packet format: accepts a byte stream over a valid/ready
//   handshake, decodes the header byte into packet_s {header, type_field} plus a payload
//   length, buffers 1..4 payload bytes, and emits one decoded result per packet over a
//   second valid/ready handshake. Sits downstream of the packet-forming datapath.
// PARAMETERS
//   P_INT        10  offset removed from the payload sum (o_result = sum - P_INT)
//   P_MAX_BYTES  4   payload buffer depth; fixed at 4 because the length field is 2 bits
// PORTS
//   i_clk      in   1   clock; all state updates on posedge
//   i_rst_n    in   1   asynchronous, active-low reset
//   i_valid    in   1   input byte valid
//   o_ready    out  1   unpacker can accept a byte this cycle
//   i_data     in   8   input byte (header byte, then payload bytes)
//   o_valid    out  1   decoded packet available
//   i_ready    in   1   downstream accepts decoded packet
//   o_header   out  4   header nibble of current packet
//   o_type     out  2   type_field of current packet
//   o_len      out  3   number of payload bytes received (1..4)
//   o_result   out  16  (sum of payload bytes - P_INT) mod 2^16
//   o_err      out  1   type_field == 2'b11 (reserved); qualified by o_valid
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE; o_valid=0, o_header=0, o_type=0,
//     o_len=0, o_result=0, o_err=0; buffer and accumulator cleared. o_ready is 1 in IDLE.
//   - Byte accepted iff i_valid && o_ready on a clock edge.
//   - FSM states IDLE, PAYLOAD, DONE:
//     IDLE:    o_ready=1. Accepted byte: header=i_data[7:4], type=i_data[3:2],
//              remaining=i_data[1:0]+1, accumulator=0, index=0 -> PAYLOAD.
//     PAYLOAD: o_ready=1. Accepted byte written to buffer[index], accumulator += byte
//              (16-bit), index++. When the last byte (index==remaining-1) is accepted:
//              register o_result=accumulator+byte-P_INT, o_len, o_header, o_type,
//              o_err, set o_valid=1 -> DONE. No accept: hold state.
//     DONE:    o_ready=0, o_valid=1, all outputs stable. On i_ready: o_valid=0 -> IDLE.
//   - Latency: o_valid rises the cycle after the last payload byte is accepted.
//   - One-cycle bubble after each output handshake (o_ready=0 in DONE); no input
//     acceptance while an output is pending -- no overwrite possible.
//   - Arithmetic: payload sum max 4*255=1020 fits 16 bits; subtraction wraps mod 2^16
//     (sum < P_INT yields two's-complement value, e.g. 5-10 = 16'hFFFB).
//   - Reserved type 2'b11: packet still consumed and reported, o_err=1; no effect on FSM.
//   - i_valid gaps inside PAYLOAD are legal; state and partial sum held indefinitely.
//   - i_valid with i_data changing while o_ready=0 is ignored.
//   - Reset mid-packet: partial packet discarded, FSM to IDLE, o_valid=0 immediately.
// STRUCTURE
//   - Shared package data_types_pkg: state_e {STATE_IDLE, STATE_PAYLOAD, STATE_DONE},
//     packet_s {logic [3:0] header; logic [1:0] type_field;}, localparam TYPE_RSVD=2'b11.
//   - Payload buffer is an unpacked array logic [7:0] buf [0:P_MAX_BYTES-1].
//   - Single module; no sub-module needed (FSM + accumulator + output register).
// TESTING (P_INT=10)
//   - Basic: bytes 8'hA5,8'h20,8'h30, i_ready=1 -> o_header=4'hA, o_type=2'b01,
//     o_len=2, o_result=16'h0046, o_err=0, o_valid one cycle after 8'h30 accepted.
//   - Wrap: bytes 8'h50,8'h05 -> o_len=1, o_result=16'hFFFB, o_type=2'b00.
//   - Max payload: 8'hA7 then four 8'hFF -> o_len=4, o_result=16'h03F2.
//   - Reserved type: 8'h3C,8'h0A -> o_header=4'h3, o_type=2'b11, o_err=1, o_result=0.
//   - Backpressure: hold i_ready=0 for 5 cycles in DONE -> o_valid stays 1, outputs
//     stable, o_ready=0, offered i_valid bytes not consumed; release -> IDLE next cycle.
//   - Reset mid-packet: 8'hA7,8'h11, assert i_rst_n=0 -> o_valid=0, o_ready=1 after
//     release; next packet 8'h50,8'h0B decodes cleanly to o_result=16'h0001.

Source files
------------

// File: rtl/data_types_pkg.sv
// Shared types for the byte-level packet format: FSM states, decoded header fields and
// the reserved type code.
package data_types_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE,
        STATE_PAYLOAD,
        STATE_DONE
    } state_e;

    typedef struct packed {
        logic [3:0] header;
        logic [1:0] type_field;
    } packet_s;

    localparam logic [1:0] TYPE_RSVD = 2'b11;

    // Header byte layout: [7:4] header nibble, [3:2] type, [1:0] payload length - 1.
    function automatic packet_s decode_header(input logic [7:0] hdr_byte);
        packet_s pkt;
        pkt.header     = hdr_byte[7:4];
        pkt.type_field = hdr_byte[3:2];
        return pkt;
    endfunction

endpackage

// File: rtl/data_types_unpacker.sv
// Receive side of the byte-level packet format. Takes a header byte followed by 1..4
// payload bytes, sums the payload, and presents one decoded result per packet until the
// downstream consumer accepts it.
module data_types_unpacker
    import data_types_pkg::*;
#(
    parameter int unsigned P_INT       = 10,
    parameter int unsigned P_MAX_BYTES = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [7:0]  i_data,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_header,
    output logic [1:0]  o_type,
    output logic [2:0]  o_len,
    output logic [15:0] o_result,
    output logic        o_err
);

    localparam logic [15:0] IntOffset = 16'(P_INT);

    state_e      state_q, state_d;
    packet_s     pkt_q;
    logic [2:0]  remaining_q;
    logic [2:0]  index_q;
    logic [15:0] acc_q;
    logic [7:0]  payload_buf [0:P_MAX_BYTES-1];

    logic        accept;
    logic        last_byte;
    logic [15:0] byte_ext;

    // Handshake decode and next-state selection.
    always_comb begin
        state_d   = state_q;
        o_ready   = (state_q != STATE_DONE);
        accept    = i_valid && o_ready;
        last_byte = (index_q == (remaining_q - 3'd1));
        byte_ext  = {8'd0, i_data};
        unique case (state_q)
            STATE_IDLE: begin
                if (accept) state_d = STATE_PAYLOAD;
            end
            STATE_PAYLOAD: begin
                if (accept && last_byte) state_d = STATE_DONE;
            end
            STATE_DONE: begin
                if (i_ready) state_d = STATE_IDLE;
            end
            default: state_d = STATE_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= STATE_IDLE;
        else          state_q <= state_d;
    end

    // Header capture, payload buffering, accumulation and the registered result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pkt_q       <= '0;
            remaining_q <= '0;
            index_q     <= '0;
            acc_q       <= '0;
            o_valid     <= 1'b0;
            o_header    <= '0;
            o_type      <= '0;
            o_len       <= '0;
            o_result    <= '0;
            o_err       <= 1'b0;
            for (int i = 0; i < int'(P_MAX_BYTES); i++) payload_buf[i] <= '0;
        end else begin
            unique case (state_q)
                STATE_IDLE: begin
                    if (accept) begin
                        pkt_q       <= decode_header(i_data);
                        remaining_q <= {1'b0, i_data[1:0]} + 3'd1;
                        acc_q       <= '0;
                        index_q     <= '0;
                    end
                end
                STATE_PAYLOAD: begin
                    if (accept) begin
                        payload_buf[index_q[1:0]] <= i_data;
                        acc_q                     <= acc_q + byte_ext;
                        index_q                   <= index_q + 3'd1;
                        if (last_byte) begin
                            // Wraps mod 2^16 when the payload sum is below the offset.
                            o_result <= acc_q + byte_ext - IntOffset;
                            o_len    <= remaining_q;
                            o_header <= pkt_q.header;
                            o_type   <= pkt_q.type_field;
                            o_err    <= (pkt_q.type_field == TYPE_RSVD);
                            o_valid  <= 1'b1;
                        end
                    end
                end
                STATE_DONE: begin
                    if (i_ready) o_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // The buffered bytes are kept for observation; the result comes from the accumulator.
    logic unused_buf;
    always_comb begin
        unused_buf = 1'b0;
        for (int i = 0; i < int'(P_MAX_BYTES); i++) begin
            unused_buf = unused_buf ^ (^payload_buf[i]);
        end
    end

endmodule

// File: tb/tb_data_types_unpacker.sv
// Self-checking bench for data_types_unpacker: directed cases followed by random packets
// compared against a packet-level reference model.
module tb_data_types_unpacker;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_data;
    logic        o_valid;
    logic        i_ready;
    logic [3:0]  o_header;
    logic [1:0]  o_type;
    logic [2:0]  o_len;
    logic [15:0] o_result;
    logic        o_err;

    int checks;
    int failures;

    data_types_unpacker #(
        .P_INT       (10),
        .P_MAX_BYTES (4)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_data   (i_data),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_header (o_header),
        .o_type   (o_type),
        .o_len    (o_len),
        .o_result (o_result),
        .o_err    (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and hold it until the unpacker takes it; returns just after the edge.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = b;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = 8'($urandom);
    endtask

    // Send a whole packet, then check the decoded output against the model, hold it under
    // backpressure for `stall` cycles while offering junk bytes, and release it.
    task automatic run_packet(input string tag, input logic [7:0] hdr, input logic [7:0] pay [$],
                              input int gaps, input int stall);
        int          sum;
        logic [3:0]  e_hdr;
        logic [1:0]  e_type;
        logic [2:0]  e_len;
        logic [15:0] e_res;
        logic        e_err;
        sum = 0;
        foreach (pay[k]) sum += int'(pay[k]);
        e_hdr  = hdr[7:4];
        e_type = hdr[3:2];
        e_len  = 3'(pay.size());
        e_res  = 16'(sum - 10);
        e_err  = (hdr[3:2] == 2'd3);

        send_byte(hdr);
        foreach (pay[k]) begin
            for (int g = 0; g < gaps; g++) @(negedge clk);
            if (k == pay.size() - 1) begin
                @(negedge clk);
                check({tag, "_valid_before_last"}, 32'(o_valid), 32'd0);
            end
            send_byte(pay[k]);
        end
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_ready_done"}, 32'(o_ready), 32'd0);
        check({tag, "_header"}, 32'(o_header), 32'(e_hdr));
        check({tag, "_type"}, 32'(o_type), 32'(e_type));
        check({tag, "_len"}, 32'(o_len), 32'(e_len));
        check({tag, "_result"}, 32'(o_result), 32'(e_res));
        check({tag, "_err"}, 32'(o_err), 32'(e_err));

        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            i_valid = 1'b1;
            i_data  = 8'($urandom);
            @(posedge clk);
            #1;
            check({tag, "_bp_valid"}, 32'(o_valid), 32'd1);
            check({tag, "_bp_ready"}, 32'(o_ready), 32'd0);
            check({tag, "_bp_result"}, 32'(o_result), 32'(e_res));
            check({tag, "_bp_header"}, 32'(o_header), 32'(e_hdr));
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        check({tag, "_released_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_released_ready"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] pay [$];
        logic [7:0] hdr;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_data   = 8'h00;
        i_ready  = 1'b0;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_header", 32'(o_header), 32'd0);
        check("rst_type", 32'(o_type), 32'd0);
        check("rst_len", 32'(o_len), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        pay = '{8'h20, 8'h30};
        run_packet("basic", 8'hA5, pay, 0, 0);
        pay = '{8'h05};
        run_packet("wrap", 8'h50, pay, 1, 0);
        pay = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_packet("max", 8'hA7, pay, 0, 1);
        pay = '{8'h0A};
        run_packet("rsvd", 8'h3C, pay, 0, 0);
        pay = '{8'h01, 8'h02};
        run_packet("backpressure", 8'h95, pay, 2, 5);

        // Reset in the middle of a packet.
        send_byte(8'hA7);
        send_byte(8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        pay = '{8'h0B};
        run_packet("after_rst", 8'h50, pay, 0, 0);

        for (int p = 0; p < 30; p++) begin
            hdr = 8'($urandom);
            pay = {};
            for (int k = 0; k <= int'(hdr[1:0]); k++) pay.push_back(8'($urandom));
            run_packet($sformatf("rand%0d", p), hdr, pay, int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
